// File: rtl/pcw_boot_pkg.sv
// Shared types for the PCW boot download path: sink state encoding and the
// buffered address/data pair carried from the loader to system RAM.
package pcw_boot_pkg;

    localparam int DL_ADDR_W = 16;

    typedef enum logic [1:0] {
        DL_IDLE,
        DL_LOAD,
        DL_DRAIN,
        DL_START
    } dl_state_t;

    typedef struct packed {
        logic [DL_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } dl_entry_t;

endpackage

// File: rtl/dl_fifo.sv
// Small synchronous FIFO of download entries. A push while full is ignored,
// and a pop while empty is ignored. The head entry is valid whenever the FIFO is not empty.
module dl_fifo
    import pcw_boot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  dl_entry_t push_data_i,
    input  logic      pop_i,
    output dl_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    dl_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; an entry is only observable after it has been written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pcw_download_sink.sv
// Boot download sink: buffers loader byte writes, commits them to RAM through an
// acknowledged port, and keeps the Z80 held until the image is in place.
module pcw_download_sink
    import pcw_boot_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 dn_go,
    input  logic                 dn_wr,
    input  logic [DL_ADDR_W-1:0] dn_addr,
    input  logic [7:0]           dn_data,
    output logic                 dn_wait,
    input  logic                 execute_enable,
    input  logic [DL_ADDR_W-1:0] execute_addr,
    output logic [DL_ADDR_W-1:0] mem_addr,
    output logic [7:0]           mem_dout,
    output logic                 mem_we,
    input  logic                 mem_ack,
    output logic                 cpu_hold,
    output logic                 cpu_start,
    output logic [DL_ADDR_W-1:0] cpu_pc,
    output logic [15:0]          byte_count,
    output logic [7:0]           checksum,
    output logic                 overflow
);

    dl_state_t            state_q, state_d;
    logic                 dn_go_q;
    logic [15:0]          byte_count_q, byte_count_d;
    logic [7:0]           checksum_q, checksum_d;
    logic                 overflow_q, overflow_d;
    logic                 exec_pending_q, exec_pending_d;
    logic [DL_ADDR_W-1:0] exec_addr_q, exec_addr_d;
    logic [DL_ADDR_W-1:0] cpu_pc_q, cpu_pc_d;
    logic                 cpu_hold_q, cpu_hold_d;

    dl_entry_t fifo_in;
    dl_entry_t fifo_head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      go_rise;

    assign go_rise   = dn_go && !dn_go_q;
    assign fifo_push = (state_q == DL_LOAD) && dn_wr;
    assign fifo_in   = '{addr: dn_addr, data: dn_data};

    dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_sys),
        .rst_i       (reset),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (mem_ack),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Write port is driven straight from FIFO occupancy so a reset drops it at once.
    assign mem_we     = !fifo_empty;
    assign mem_addr   = fifo_empty ? '0 : fifo_head.addr;
    assign mem_dout   = fifo_empty ? '0 : fifo_head.data;
    assign dn_wait    = fifo_full;
    assign cpu_start  = (state_q == DL_START);
    assign cpu_hold   = cpu_hold_q;
    assign cpu_pc     = cpu_pc_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;
    assign overflow   = overflow_q;

    // NOTE: every next-state value defaults to its register first, so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        byte_count_d   = byte_count_q;
        checksum_d     = checksum_q;
        overflow_d     = overflow_q;
        exec_pending_d = exec_pending_q;
        exec_addr_d    = exec_addr_q;
        cpu_pc_d       = cpu_pc_q;
        cpu_hold_d     = cpu_hold_q;

        case (state_q)
            DL_IDLE: begin
                if (go_rise) begin
                    state_d      = DL_LOAD;
                    byte_count_d = '0;
                    checksum_d   = '0;
                    overflow_d   = 1'b0;
                    cpu_hold_d   = 1'b1;
                end else if (execute_enable && cpu_hold_q) begin
                    exec_addr_d = execute_addr;
                    state_d     = DL_START;
                end
            end
            DL_LOAD: begin
                if (dn_wr) begin
                    if (!fifo_full) begin
                        byte_count_d = (byte_count_q == 16'hFFFF) ? byte_count_q
                                                                  : byte_count_q + 16'd1;
                        checksum_d   = checksum_q + dn_data;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (execute_enable) begin
                    exec_pending_d = 1'b1;
                    exec_addr_d    = execute_addr;
                end
                if (!dn_go) begin
                    state_d = DL_DRAIN;
                end
            end
            DL_DRAIN: begin
                if (go_rise) begin
                    // New session: queued bytes keep draining, bookkeeping restarts.
                    state_d        = DL_LOAD;
                    byte_count_d   = '0;
                    checksum_d     = '0;
                    overflow_d     = 1'b0;
                    exec_pending_d = 1'b0;
                end else begin
                    if (execute_enable) begin
                        exec_pending_d = 1'b1;
                        exec_addr_d    = execute_addr;
                    end
                    if (fifo_empty && exec_pending_q) begin
                        state_d = DL_START;
                    end
                end
            end
            DL_START: begin
                cpu_pc_d       = exec_addr_q;
                cpu_hold_d     = 1'b0;
                exec_pending_d = 1'b0;
                state_d        = DL_IDLE;
            end
            default: state_d = DL_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q        <= DL_IDLE;
            dn_go_q        <= 1'b0;
            byte_count_q   <= '0;
            checksum_q     <= '0;
            overflow_q     <= 1'b0;
            exec_pending_q <= 1'b0;
            exec_addr_q    <= '0;
            cpu_pc_q       <= '0;
            cpu_hold_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            dn_go_q        <= dn_go;
            byte_count_q   <= byte_count_d;
            checksum_q     <= checksum_d;
            overflow_q     <= overflow_d;
            exec_pending_q <= exec_pending_d;
            exec_addr_q    <= exec_addr_d;
            cpu_pc_q       <= cpu_pc_d;
            cpu_hold_q     <= cpu_hold_d;
        end
    end

endmodule

// File: tb/tb_pcw_download_sink.sv
// Scenario bench for pcw_download_sink: expected RAM writes are queued as bytes are
// strobed and retired as the write port completes them; counters come from a local model.
module tb_pcw_download_sink;
    import pcw_boot_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b0;
    logic        dn_go = 1'b0;
    logic        dn_wr = 1'b0;
    logic [15:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic        dn_wait;
    logic        execute_enable = 1'b0;
    logic [15:0] execute_addr = '0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic        cpu_hold;
    logic        cpu_start;
    logic [15:0] cpu_pc;
    logic [15:0] byte_count;
    logic [7:0]  checksum;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    int starts = 0;

    dl_entry_t   exp_q[$];
    int          exp_count;
    logic [7:0]  exp_sum;
    logic [7:0]  ram [65536];

    pcw_download_sink #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .dn_go          (dn_go),
        .dn_wr          (dn_wr),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wait        (dn_wait),
        .execute_enable (execute_enable),
        .execute_addr   (execute_addr),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .mem_we         (mem_we),
        .mem_ack        (mem_ack),
        .cpu_hold       (cpu_hold),
        .cpu_start      (cpu_start),
        .cpu_pc         (cpu_pc),
        .byte_count     (byte_count),
        .checksum       (checksum),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // Retire completed RAM writes against the scoreboard, mid-cycle.
    always @(negedge clk_sys) begin
        if (mem_we === 1'b1 && mem_ack === 1'b1) begin
            dl_entry_t e;
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%h data=%h, required no write", mem_addr, mem_dout);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_dout} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL write_order got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_dout, e.addr, e.data);
                end
            end
            ram[mem_addr] = mem_dout;
        end
        if (cpu_start === 1'b1) begin
            starts++;
            checks++;
            if (cpu_hold !== 1'b1) begin
                errors++;
                $display("FAIL start_with_hold got cpu_hold=%b, required 1", cpu_hold);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit accept);
        dl_entry_t e;
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        if (accept) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
            exp_count++;
            exp_sum += d;
        end
        tick();
        dn_wr = 1'b0;
    endtask

    task automatic drain_queue(input int budget, input string name);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d writes outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_we, cpu_hold, dn_wait, cpu_start, overflow} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_flags got we/hold/wait/start/ovf=%b, required 01000",
                     {mem_we, cpu_hold, dn_wait, cpu_start, overflow});
        end
        checks++;
        if ({cpu_pc, mem_addr, mem_dout, byte_count, checksum} !== '0) begin
            errors++;
            $display("FAIL reset_values got pc=%h addr=%h dout=%h count=%h sum=%h, required all 0",
                     cpu_pc, mem_addr, mem_dout, byte_count, checksum);
        end
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (cpu_hold !== 1'b1 || cpu_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got hold=%b start=%b, required hold=1 start=0", cpu_hold, cpu_start);
        end
    endtask

    task automatic test_full_session();
        int s0;
        int w0;
        int bad;
        s0 = starts;
        w0 = writes;
        exp_count = 0;
        exp_sum = '0;
        mem_ack = 1'b1;
        dn_go = 1'b1;
        tick();
        for (int i = 0; i < 276; i++) send_byte(16'(i), 8'(i), 1'b1);
        dn_go = 1'b0;
        execute_enable = 1'b1;
        execute_addr = 16'h0000;
        tick();
        execute_enable = 1'b0;
        checks++;
        if (cpu_start !== 1'b0) begin
            errors++;
            $display("FAIL full_start_early got cpu_start=%b in DRAIN cycle, required 0", cpu_start);
        end
        tick();
        checks++;
        if (cpu_start !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL full_start_timing got start=%b hold=%b, required start=1 hold=1", cpu_start, cpu_hold);
        end
        tick();
        checks++;
        if (cpu_start !== 1'b0 || cpu_hold !== 1'b0 || cpu_pc !== 16'h0000) begin
            errors++;
            $display("FAIL full_release got start=%b hold=%b pc=%h, required 0 0 0000", cpu_start, cpu_hold, cpu_pc);
        end
        checks++;
        if (byte_count !== 16'(exp_count) || checksum !== exp_sum) begin
            errors++;
            $display("FAIL full_counters got count=%0d sum=%h, required count=%0d sum=%h",
                     byte_count, checksum, exp_count, exp_sum);
        end
        checks++;
        if (starts - s0 != 1 || writes - w0 != 276 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_totals got starts=%0d writes=%0d left=%0d, required 1 276 0",
                     starts - s0, writes - w0, exp_q.size());
        end
        bad = -1;
        for (int i = 0; i < 276; i++) begin
            logic [15:0] iv;
            iv = 16'(i);
            if (bad < 0 && ram[i] !== iv[7:0]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL full_ram_image got ram[%0d] wrong, required identical image", bad);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] d;
        exp_count = 0;
        exp_sum = '0;
        mem_ack = 1'b0;
        dn_go = 1'b1;
        tick();
        checks++;
        if (byte_count !== 16'd0 || checksum !== 8'd0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL bp_session_clear got count=%0d sum=%h hold=%b, required 0 00 1",
                     byte_count, checksum, cpu_hold);
        end
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send_byte(16'h1000 + 16'(i), d, 1'b1);
        end
        checks++;
        if (dn_wait !== 1'b1 || byte_count !== 16'd4) begin
            errors++;
            $display("FAIL bp_full got wait=%b count=%0d, required wait=1 count=4", dn_wait, byte_count);
        end
        send_byte(16'h1FFF, 8'hAA, 1'b0);
        checks++;
        if (overflow !== 1'b1 || byte_count !== 16'd4 || checksum !== exp_sum) begin
            errors++;
            $display("FAIL bp_overflow got ovf=%b count=%0d sum=%h, required ovf=1 count=4 sum=%h",
                     overflow, byte_count, checksum, exp_sum);
        end
        mem_ack = 1'b1;
        drain_queue(20, "bp_release");
        mem_ack = 1'b0;
        checks++;
        if (dn_wait !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty got wait=%b we=%b, required 0 0", dn_wait, mem_we);
        end
    endtask

    task automatic test_exec_during_drain();
        int s0;
        mem_ack = 1'b0;
        execute_enable = 1'b1;
        execute_addr = 16'h5555;
        send_byte(16'h3000, 8'h11, 1'b1);
        execute_enable = 1'b0;
        send_byte(16'h3001, 8'h22, 1'b1);
        send_byte(16'h3002, 8'h33, 1'b1);
        s0 = starts;
        dn_go = 1'b0;
        execute_enable = 1'b1;
        execute_addr = 16'h1234;
        tick();
        execute_enable = 1'b0;
        repeat (5) tick();
        checks++;
        if (starts != s0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL drain_start_early got starts=%0d hold=%b, required 0 1", starts - s0, cpu_hold);
        end
        for (int k = 0; k < 3; k++) begin
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            if (k < 2) tick();
        end
        checks++;
        if (cpu_start !== 1'b0 || starts != s0) begin
            errors++;
            $display("FAIL drain_last_ack got start=%b, required 0 right after final ack", cpu_start);
        end
        tick();
        checks++;
        if (cpu_start !== 1'b1) begin
            errors++;
            $display("FAIL drain_start got cpu_start=%b, required 1", cpu_start);
        end
        tick();
        checks++;
        if (cpu_pc !== 16'h1234 || cpu_hold !== 1'b0 || starts - s0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_pc got pc=%h hold=%b starts=%0d left=%0d, required 1234 0 1 0",
                     cpu_pc, cpu_hold, starts - s0, exp_q.size());
        end
    endtask

    task automatic test_restart_drain();
        int s0;
        exp_count = 0;
        exp_sum = '0;
        mem_ack = 1'b0;
        dn_go = 1'b1;
        tick();
        checks++;
        if (cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL restart_hold got cpu_hold=%b, required 1", cpu_hold);
        end
        send_byte(16'h4000, 8'h5A, 1'b1);
        send_byte(16'h4001, 8'hA5, 1'b1);
        send_byte(16'h4002, 8'h0F, 1'b1);
        s0 = starts;
        dn_go = 1'b0;
        execute_enable = 1'b1;
        execute_addr = 16'hBEEF;
        tick();
        execute_enable = 1'b0;
        repeat (2) tick();
        dn_go = 1'b1;
        tick();
        exp_count = 0;
        exp_sum = '0;
        checks++;
        if (byte_count !== 16'd0 || checksum !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear got count=%0d sum=%h ovf=%b, required 0 00 0",
                     byte_count, checksum, overflow);
        end
        dn_go = 1'b0;
        tick();
        mem_ack = 1'b1;
        drain_queue(20, "restart_writes");
        mem_ack = 1'b0;
        repeat (10) tick();
        checks++;
        if (starts != s0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL restart_held got starts=%0d hold=%b, required 0 1", starts - s0, cpu_hold);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        exp_count = 0;
        exp_sum = '0;
        dn_go = 1'b1;
        tick();
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) send_byte(16'h2000 + 16'(i), 8'(i * 7 + 3), 1'b1);
        checks++;
        if (mem_we !== 1'b1 || byte_count !== 16'd10) begin
            errors++;
            $display("FAIL mid_load_state got we=%b count=%0d, required 1 10", mem_we, byte_count);
        end
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({mem_we, cpu_hold, dn_wait, cpu_start, overflow} !== 5'b01000) begin
            errors++;
            $display("FAIL mid_reset_flags got we/hold/wait/start/ovf=%b, required 01000",
                     {mem_we, cpu_hold, dn_wait, cpu_start, overflow});
        end
        checks++;
        if ({cpu_pc, mem_addr, mem_dout, byte_count, checksum} !== '0) begin
            errors++;
            $display("FAIL mid_reset_values got pc=%h addr=%h dout=%h count=%h sum=%h, required all 0",
                     cpu_pc, mem_addr, mem_dout, byte_count, checksum);
        end
        dn_go = 1'b0;
        w0 = writes;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if (writes != w0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_quiet got writes=%0d hold=%b, required 0 1", writes - w0, cpu_hold);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_session();
        test_backpressure();
        test_exec_during_drain();
        test_restart_drain();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
